iob_eth_rx_deframer: RTL

MII receive deframer for the iob_eth core. Sits directly downstream of the PHY/MII pins, the same pins the loopback testbench generator drives.
- Strips preamble/SFD, assembles nibbles into bytes, and writes each byte into a byte-wide RX frame buffer.
- Checks the FCS with a running CRC-32.
- Reports frame length and error status to the core's register interface.
- One frame is held until software re-arms.

---
 rtl/iob_eth_rx_deframer_pkg.sv | 32 +++
 rtl/iob_eth_rx_deframer_if.sv | 32 +++
 rtl/iob_eth_rx_deframer_crc.sv | 31 +++
 rtl/iob_eth_rx_deframer.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/iob_eth_rx_deframer_pkg.sv
// Shared constants, state encoding and the byte-wide reflected CRC-32 step
// used by the iob_eth MII receive deframer.
package iob_eth_rx_deframer_pkg;

  localparam logic [3:0]  PRE_NIB       = 4'h5;
  localparam logic [3:0]  SFD_NIB       = 4'hD;
  localparam logic [31:0] CRC_INIT      = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB_20E3;
  localparam logic [31:0] CRC_POLY      = 32'hEDB8_8320;
  localparam int          DEF_MIN_FRAME = 64;
  localparam int          DEF_MAX_FRAME = 1518;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PRE   = 3'd1,
    ST_DATA  = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4,
    ST_SKIP  = 3'd5
  } rx_state_t;

  // One byte through the reflected CRC-32, LSB first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'h00_0000, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/iob_eth_rx_deframer_if.sv
// MII receive pins, RX buffer write port and frame status of the deframer.
interface iob_eth_rx_deframer_if #(
  parameter int BUF_ADDR_W = 11
);

  logic                  rx_dv;
  logic [3:0]            rx_data;
  logic                  rx_arm;
  logic [BUF_ADDR_W-1:0] buf_addr;
  logic [7:0]            buf_wdata;
  logic                  buf_we;
  logic                  rx_busy;
  logic                  rx_done;
  logic [15:0]           rx_len;
  logic                  rx_crc_ok;
  logic                  rx_err_runt;
  logic                  rx_err_long;
  logic                  rx_err_odd;

  modport slave (
    input  rx_dv, rx_data, rx_arm,
    output buf_addr, buf_wdata, buf_we,
    output rx_busy, rx_done, rx_len, rx_crc_ok, rx_err_runt, rx_err_long, rx_err_odd
  );

  modport master (
    output rx_dv, rx_data, rx_arm,
    input  buf_addr, buf_wdata, buf_we,
    input  rx_busy, rx_done, rx_len, rx_crc_ok, rx_err_runt, rx_err_long, rx_err_odd
  );

endinterface

// File: rtl/iob_eth_rx_deframer_crc.sv
// Byte-wide reflected CRC-32 accumulator: start reloads the seed, data_en
// folds one byte in.
module iob_eth_rx_deframer_crc
  import iob_eth_rx_deframer_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        data_en,
  input  logic [7:0]  data,
  output logic [31:0] crc
);

  logic [31:0] crc_r;

  // CRC register: seed on start, advance one byte per data_en.
  always_ff @(posedge clk) begin
    if (reset) begin
      crc_r <= CRC_INIT;
    end else if (start) begin
      crc_r <= CRC_INIT;
    end else if (data_en) begin
      crc_r <= crc32_byte(crc_r, data);
    end else begin
      crc_r <= crc_r;
    end
  end

  assign crc = crc_r;

endmodule

// File: rtl/iob_eth_rx_deframer.sv
// MII receive deframer: strips preamble/SFD, packs nibbles into buffer bytes,
// checks FCS and holds one frame's status until software re-arms.
module iob_eth_rx_deframer
  import iob_eth_rx_deframer_pkg::*;
#(
  parameter int BUF_ADDR_W = 11,
  parameter int MIN_FRAME  = DEF_MIN_FRAME,
  parameter int MAX_FRAME  = DEF_MAX_FRAME
) (
  input logic                  clk,
  input logic                  reset,
  iob_eth_rx_deframer_if.slave bus
);

  localparam logic [16:0] BUF_DEPTH = 17'd1 << BUF_ADDR_W;
  localparam logic [15:0] MIN_LEN   = 16'(MIN_FRAME);
  localparam logic [15:0] MAX_LEN   = 16'(MAX_FRAME);

  rx_state_t             state_r;
  logic [3:0]            nib_lo_r;
  logic                  phase_r;
  logic [15:0]           cnt_r;
  logic                  ovf_r;
  logic                  odd_r;
  logic                  buf_we_r;
  logic [7:0]            buf_wdata_r;
  logic [BUF_ADDR_W-1:0] buf_addr_r;
  logic                  rx_busy_r;
  logic                  rx_done_r;
  logic [15:0]           rx_len_r;
  logic                  rx_crc_ok_r;
  logic                  rx_err_runt_r;
  logic                  rx_err_long_r;
  logic                  rx_err_odd_r;
  logic                  sfd_s;
  logic                  cnt_full_s;
  logic [31:0]           crc_s;

  // SFD seen while hunting: restarts the CRC and the byte bookkeeping.
  always_comb begin
    sfd_s = 1'b0;
    if ((state_r == ST_IDLE || state_r == ST_PRE) && bus.rx_dv && (bus.rx_data == SFD_NIB)) begin
      sfd_s = 1'b1;
    end else begin
      sfd_s = 1'b0;
    end
  end

  assign cnt_full_s = ({1'b0, cnt_r} >= BUF_DEPTH);

  iob_eth_rx_deframer_crc u_crc (
    .clk     (clk),
    .reset   (reset),
    .start   (sfd_s),
    .data_en (buf_we_r),
    .data    (buf_wdata_r),
    .crc     (crc_s)
  );

  // Receive FSM with registered write port and status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= ST_IDLE;
      nib_lo_r      <= 4'h0;
      phase_r       <= 1'b0;
      cnt_r         <= 16'd0;
      ovf_r         <= 1'b0;
      odd_r         <= 1'b0;
      buf_we_r      <= 1'b0;
      buf_wdata_r   <= 8'h00;
      buf_addr_r    <= {BUF_ADDR_W{1'b0}};
      rx_busy_r     <= 1'b0;
      rx_done_r     <= 1'b0;
      rx_len_r      <= 16'd0;
      rx_crc_ok_r   <= 1'b0;
      rx_err_runt_r <= 1'b0;
      rx_err_long_r <= 1'b0;
      rx_err_odd_r  <= 1'b0;
    end else begin
      buf_we_r <= 1'b0;
      if (sfd_s) begin
        cnt_r      <= 16'd0;
        phase_r    <= 1'b0;
        ovf_r      <= 1'b0;
        buf_addr_r <= {BUF_ADDR_W{1'b0}};
      end
      case (state_r)
        ST_IDLE: begin
          if (bus.rx_dv && bus.rx_data == PRE_NIB) begin
            state_r   <= ST_PRE;
            rx_busy_r <= 1'b1;
          end else if (sfd_s) begin
            state_r   <= ST_DATA;
            rx_busy_r <= 1'b1;
          end else if (bus.rx_dv) begin
            state_r   <= ST_SKIP;
          end
        end
        ST_PRE: begin
          if (!bus.rx_dv) begin
            state_r   <= ST_IDLE;
            rx_busy_r <= 1'b0;
          end else if (sfd_s) begin
            state_r   <= ST_DATA;
          end else if (bus.rx_data != PRE_NIB) begin
            state_r   <= ST_SKIP;
            rx_busy_r <= 1'b0;
          end
        end
        ST_DATA: begin
          if (!bus.rx_dv) begin
            state_r   <= ST_CHECK;
            rx_busy_r <= 1'b0;
            odd_r     <= phase_r;
          end else if (!phase_r) begin
            nib_lo_r <= bus.rx_data;
            phase_r  <= 1'b1;
          end else begin
            phase_r <= 1'b0;
            // Past the end of the buffer bytes are still counted, just not stored.
            if (!cnt_full_s) begin
              buf_we_r    <= 1'b1;
              buf_wdata_r <= {bus.rx_data, nib_lo_r};
              buf_addr_r  <= cnt_r[BUF_ADDR_W-1:0];
            end else begin
              ovf_r <= 1'b1;
            end
            if (cnt_r != 16'hFFFF) begin
              cnt_r <= cnt_r + 16'd1;
            end
          end
        end
        ST_CHECK: begin
          state_r       <= ST_DONE;
          rx_done_r     <= 1'b1;
          rx_len_r      <= cnt_r;
          rx_crc_ok_r   <= (crc_s == CRC_RESIDUE);
          rx_err_runt_r <= (cnt_r < MIN_LEN);
          rx_err_long_r <= (cnt_r > MAX_LEN) || ovf_r;
          rx_err_odd_r  <= odd_r;
        end
        ST_DONE: begin
          if (bus.rx_arm) begin
            state_r       <= bus.rx_dv ? ST_SKIP : ST_IDLE;
            rx_done_r     <= 1'b0;
            rx_len_r      <= 16'd0;
            rx_crc_ok_r   <= 1'b0;
            rx_err_runt_r <= 1'b0;
            rx_err_long_r <= 1'b0;
            rx_err_odd_r  <= 1'b0;
          end
        end
        ST_SKIP: begin
          if (!bus.rx_dv) begin
            state_r <= ST_IDLE;
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          rx_busy_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.buf_we      = buf_we_r;
  assign bus.buf_wdata   = buf_wdata_r;
  assign bus.buf_addr    = buf_addr_r;
  assign bus.rx_busy     = rx_busy_r;
  assign bus.rx_done     = rx_done_r;
  assign bus.rx_len      = rx_len_r;
  assign bus.rx_crc_ok   = rx_crc_ok_r;
  assign bus.rx_err_runt = rx_err_runt_r;
  assign bus.rx_err_long = rx_err_long_r;
  assign bus.rx_err_odd  = rx_err_odd_r;

endmodule
